fetch_decode_queue: RTL

// Parametrised fetch/decode front end for the multicycle core. Holds the fetch PC, fetches instruction

---
 rtl/fetch_decode_queue_if.sv | 36 +++
 rtl/fetch_decode_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode front-end bundle: memory fetch handshake, redirect, and decoded queue head.
// master = the fetch/decode queue, slave = memory + control FSM side.
interface fetch_decode_queue_if #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned OPCODE_WIDTH = 5
);
    logic                               MemReq;
    logic [ADDR_WIDTH-1:0]              MemAddr;
    logic                               MemReady;
    logic [DATA_WIDTH-1:0]              MemData;
    logic                               PC_Write;
    logic [ADDR_WIDTH-1:0]              PC_Target;
    logic                               IR_Accept;
    logic                               IR_Valid;
    logic [DATA_WIDTH-1:0]              Instruction;
    logic [ADDR_WIDTH-1:0]              InstrPC;
    logic [ADDR_WIDTH-1:0]              NextPC;
    logic [OPCODE_WIDTH-1:0]            Opcode;
    logic [DATA_WIDTH-OPCODE_WIDTH-1:0] InstrParam;
    logic [DATA_WIDTH-1:0]              ZE;
    logic [DATA_WIDTH-1:0]              SE;
    logic [DATA_WIDTH-1:0]              SEL1;

    modport master (
        output MemReq, MemAddr, IR_Valid, Instruction, InstrPC, NextPC,
               Opcode, InstrParam, ZE, SE, SEL1,
        input  MemReady, MemData, PC_Write, PC_Target, IR_Accept
    );

    modport slave (
        input  MemReq, MemAddr, IR_Valid, Instruction, InstrPC, NextPC,
               Opcode, InstrParam, ZE, SE, SEL1,
        output MemReady, MemData, PC_Write, PC_Target, IR_Accept
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Fetch/decode front end: fetches instruction words into a DEPTH-entry prefetch queue and
// presents the decoded head; supports redirect with queue flush and in-flight response discard.
module fetch_decode_queue #(
    parameter int unsigned          DATA_WIDTH   = 16,
    parameter int unsigned          ADDR_WIDTH   = 16,
    parameter int unsigned          OPCODE_WIDTH = 5,
    parameter int unsigned          IMM_WIDTH    = 8,
    parameter int unsigned          DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                  Clock,
    input logic                  Reset,
    fetch_decode_queue_if.master bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned EXT_W   = DATA_WIDTH - IMM_WIDTH;
    localparam int unsigned PARAM_W = DATA_WIDTH - OPCODE_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] word;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_req_q, mem_req_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    entry_t                q_mem_q [DEPTH];
    entry_t                q_mem_d [DEPTH];

    logic                  push_c;
    logic                  pop_c;
    logic                  ir_valid_c;
    entry_t                head_c;
    logic [DATA_WIDTH-1:0] instr_c;
    logic [IMM_WIDTH-1:0]  imm_c;
    logic [DATA_WIDTH-1:0] se_c;

    // A redirect kills both the arriving response and any pop in the same cycle.
    assign push_c     = (state_q == ST_WAIT) && bus.MemReady && !bus.PC_Write;
    assign ir_valid_c = (count_q != '0);
    assign pop_c      = bus.IR_Accept && ir_valid_c && !bus.PC_Write;

    // Circular queue bookkeeping.
    always_comb begin
        q_mem_d  = q_mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.PC_Write) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                q_mem_d[wr_ptr_q] = '{pc: fetch_pc_q, word: bus.MemData};
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Fetch FSM; a request is only issued when the post-pop occupancy leaves a slot free.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.PC_Write) begin
                    fetch_pc_d = bus.PC_Target;
                end else if (count_d < CNT_W'(DEPTH)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.PC_Write) begin
                    fetch_pc_d = bus.PC_Target;
                    state_d    = bus.MemReady ? ST_IDLE : ST_DISCARD;
                end else if (bus.MemReady) begin
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
                    if (count_d >= CNT_W'(DEPTH)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (bus.PC_Write) begin
                    fetch_pc_d = bus.PC_Target;
                end
                if (bus.MemReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // DISCARD keeps presenting the abandoned address until its response arrives.
        if (state_d == ST_WAIT) begin
            mem_addr_d = fetch_pc_d;
        end else if (state_d == ST_IDLE) begin
            mem_addr_d = '0;
        end
        mem_req_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            q_mem_q    <= q_mem_d;
        end
    end

    // Head presentation and decode; everything reads as zero while the queue is empty.
    assign head_c  = q_mem_q[rd_ptr_q];
    assign instr_c = ir_valid_c ? head_c.word : '0;
    assign imm_c   = instr_c[IMM_WIDTH-1:0];
    assign se_c    = {{EXT_W{imm_c[IMM_WIDTH-1]}}, imm_c};

    assign bus.MemReq      = mem_req_q;
    assign bus.MemAddr     = mem_addr_q;
    assign bus.IR_Valid    = ir_valid_c;
    assign bus.Instruction = instr_c;
    assign bus.InstrPC     = ir_valid_c ? head_c.pc : '0;
    assign bus.NextPC      = ir_valid_c ? head_c.pc + ADDR_WIDTH'(1) : '0;
    assign bus.Opcode      = instr_c[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign bus.InstrParam  = instr_c[PARAM_W-1:0];
    assign bus.ZE          = {{EXT_W{1'b0}}, imm_c};
    assign bus.SE          = se_c;
    assign bus.SEL1        = {se_c[DATA_WIDTH-2:0], 1'b0};

endmodule
